// File: rtl/seq_modreduce.sv
// seq_modreduce: bit-serial reduction of a 2W-bit product modulo a W-bit modulus.
// One operand bit is shifted into the accumulator per cycle (MSB first), with a
// single conditional subtract keeping the accumulator below the modulus.
module seq_modreduce #(
    parameter int unsigned W = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   in_x,
    input  logic [W-1:0]     in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_r,
    output logic             out_err
);

    localparam int unsigned XW = 2 * W;
    localparam int unsigned CW = $clog2(XW);
    localparam logic [CW-1:0] LAST_BIT = CW'(XW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [W-1:0]    m_q, m_d;
    logic [W:0]      r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_r_q, out_r_d;
    logic            out_err_q, out_err_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [W:0]      t_c;
    logic [W:0]      m_ext_c;
    logic [W:0]      diff_c;
    logic            ge_c;

    // One reduction step: t = 2r + next bit, then at most one subtract of m.
    always_comb begin
        t_c     = (r_q << 1) | (W + 1)'(x_q[XW-1]);
        m_ext_c = {1'b0, m_q};
        diff_c  = t_c - m_ext_c;
        ge_c    = (t_c >= m_ext_c);
    end

    // Next-state and datapath update; outputs are registered from next state.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        m_d       = m_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        out_r_d   = out_r_q;
        out_err_d = out_err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d   = in_x;
                    m_d   = in_m;
                    r_d   = '0;
                    cnt_d = '0;
                    if (in_m != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d   = DONE;
                        out_r_d   = '0;
                        out_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                r_d   = ge_c ? diff_c : t_c;
                x_d   = {x_q[XW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d   = DONE;
                    out_r_d   = r_d[W-1:0];
                    out_err_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Control, accumulator and result registers; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            cnt_q       <= '0;
            out_r_q     <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_r_q     <= out_r_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Captured operands; only meaningful while an operation is in flight.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        m_q <= m_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/seq_modreduce.md
SEQ_MODREDUCE -- requirements
Module: seq_modreduce

Interface
REQ-001 SHALL have parameter W, default 1024, giving modulus and result width in bits; W >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 SHALL have port in_x, input, 2W bits: the wide product to reduce (squarer output).
REQ-007 SHALL have port in_m, input, W bits: the modulus.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_r, output, W bits: in_x mod in_m.
REQ-011 SHALL have port out_err, output, 1 bit: high with out_valid when in_m was 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 Accept: an edge with in_valid & in_ready SHALL capture in_x and in_m, then:
  - clear accumulator r (W+1 bits) and bit counter;
  - if in_m != 0, go to RUN;
  - if in_m == 0, go to DONE with out_r = 0 and out_err = 1.
REQ-015 In RUN, each cycle SHALL consume one bit of captured x, MSB first (bit 2W-1 down to 0), as follows:
  - t = 2r + bit;
  - r = t - m if t >= m, else r = t;
  - invariant r < m holds after every step.
REQ-016 Arithmetic SHALL use W+1-bit intermediates so that t < 2m never overflows; only one conditional subtract per step.
REQ-017 RUN SHALL last exactly 2W cycles, then go to DONE with out_r = r[W-1:0] and out_err = 0.
REQ-018 Fixed latency: with acceptance at edge 0, out_valid SHALL be visible after edge 2W+1 (m != 0) or after edge 1 (m == 0).
REQ-019 In DONE, out_r and out_err SHALL hold stable while out_ready = 0.
REQ-020 An edge in DONE with out_ready = 1 SHALL go to IDLE; out_valid falls and in_ready rises together.
REQ-021 There is no overlap: at least one IDLE cycle separates consecutive results.
REQ-022 Changes on in_x and in_m outside the accept edge SHALL have no effect.
REQ-023 SHALL give a correct result for every m >= 1, including m = 1 (result 0) and x < m (result x).
REQ-024 in_valid while busy SHALL be ignored; no queuing.

Reset
REQ-025 reset = 1 at an edge SHALL force IDLE from any state, including mid-RUN, and abandon the operation in flight.
REQ-026 After that edge, outputs SHALL be: in_ready = 1, out_valid = 0, out_r = 0, out_err = 0; accumulator and counter cleared.
REQ-027 reset SHALL take priority over a simultaneous accept or out_ready.

Verification (W = 8 unless stated)
REQ-028 Latency check:
  - stimulus: x = 0xFFFF, m = 0xFB;
  - response: out_r = 0x18, out_err = 0, out_valid first seen after edge 17 counted from accept.
REQ-029 x = 0x1234, m = 0x80 SHALL give out_r = 0x34. x = 0x0005, m = 0x07 SHALL give out_r = 0x05. m = 0x01 SHALL give out_r = 0x00.
REQ-030 m = 0x00, x = 0xABCD SHALL give out_valid after edge 1, out_err = 1, out_r = 0x00.
REQ-031 Backpressure:
  - stimulus: hold out_ready = 0 for 5 cycles in DONE and toggle in_x/in_m meanwhile;
  - response: out_r stable, in_ready = 0; IDLE one edge after out_ready = 1.
REQ-032 Reset mid-operation:
  - stimulus: assert reset at RUN cycle 5;
  - response: next cycle in_ready = 1, out_valid = 0; a new operation then returns the correct result.
REQ-033 Random regression at W = 1024: SHALL compare out_r against a software model of x mod m on at least 1000 random pairs, including m with the MSB set.
